alu_display_scan: RTL
=====================

Name: alu_display_scan

Overview:
- Downstream consumer of the ALU and control-unit outputs.
- Captures the 4-bit ALU result, the 5-bit ALU flags and the 4-bit program counter on a load strobe.
- Drives a 4-digit, common-anode, multiplexed 7-segment display with blanking between digits.
- Flags value changes with a one-cycle pulse for debug LEDs or logic analyzers.

Parameters:
- SCAN_DIV, 12500, clock cycles each digit stays lit (SHOW length); legal range >= 2.
- BLANK_CYC, 16, clock cycles all anodes are off between digits (anti-ghosting); legal range >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iResultado  input  4  ALU result.
- iFlags  input  5  ALU flags.
- iContador  input  4  control-unit program counter.
- iLoad  input  1  capture strobe; samples all data inputs at the clock edge.
- oSeg  output  7  segments {g,f,e,d,c,b,a}, active low.
- oDp  output  1  decimal point, active low.
- oAnodo  output  4  digit enables, active low; bit0 = digit0.
- oUpdate  output  1  one-cycle pulse when captured data changed.

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock edge needed):
  - oAnodo=4'hF, oSeg=7'h7F, oDp=1, oUpdate=0.
  - Held registers cleared to 0.
  - FSM=BLANK, digit index=3, prescaler=0.
- Capture:
  - iLoad=1 at an edge loads {iResultado, iContador, iFlags} into the held registers.
  - At that same edge, oUpdate is registered to 1 if the new value differs from the previous held value, otherwise 0.
  - oUpdate is 0 in every cycle without a load.
  - With iLoad=0 the held registers keep their value; input changes are ignored.
- FSM, two states:
  - SHOW: lasts exactly SCAN_DIV cycles, then goes to BLANK.
  - BLANK: lasts exactly BLANK_CYC cycles, then the digit index advances (3 wraps to 0) and the FSM enters SHOW.
  - Frame period = 4*(SCAN_DIV+BLANK_CYC) cycles.
  - Capture never affects FSM timing.
- Digit content:
  - digit0 = hex(held result).
  - digit1 = hex(held counter).
  - digit2 = hex(held flags[3:0]).
  - digit3 = hex({3'b0, held flags[4]}).
- Hex encoding (active low, g..a), 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- oDp = 0 only while digit3 is shown and held flags != 0; otherwise 1.
- Output registers:
  - oSeg, oAnodo and oDp are registers loaded every edge from next FSM state, next index and the current held registers.
  - A capture at edge N is visible on oSeg at edge N+1 if the relevant digit is being shown.
  - In BLANK: oAnodo=4'hF, oSeg=7'h7F, oDp=1.
- After reset release: BLANK_CYC cycles of BLANK, then digit0 SHOW.
- Exactly one anode is low at any time in SHOW, none in BLANK.

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined:
  - A 6-bit frame counter increments on each 3->0 index wrap and resets to 0.
  - While held flags[4]=1 and frame counter bit5=1, digit0 stays dark during its SHOW slot (oAnodo=4'hF, oSeg=7'h7F). FSM timing is unchanged.
- Undefined: no frame counter; digit0 is always lit in its slot.

Test Plan (SCAN_DIV=4, BLANK_CYC=2):
- Reset: hold iRst_n=0 -> oAnodo=F, oSeg=7F, oDp=1, oUpdate=0. Release -> 2 cycles dark, then oAnodo=1110 with oSeg=40 for 4 cycles.
- Scan order: run 30 cycles -> oAnodo sequence 1110, 1111x2, 1101, 1111x2, 1011, 1111x2, 0111, 1111x2, 1110; 4 lit cycles per digit; 24-cycle frame.
- Load: pulse iLoad with result=A, counter=3, flags=00 -> oUpdate=1 for one cycle; digit0 oSeg=08; digit1 oSeg=30; digit2 and digit3 oSeg=40; oDp=1 always.
- Repeat-load and hold: reload the identical value -> oUpdate stays 0. Change inputs with iLoad=0 -> display unchanged.
- Flags: load flags=10 -> digit3 oSeg=79 with oDp=0; digit2 oSeg=40.
- Async reset: assert iRst_n=0 mid-SHOW between clock edges -> oAnodo=F immediately. After release, all digits show oSeg=40.

Source files
------------

// File: rtl/alu_display_scan.sv
// Latches ALU result, flags and program counter, and scans them onto a 4-digit
// common-anode 7-segment display. Optional macro DISP_BLINK_EN blinks digit0 on flags[4].
module alu_display_scan #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       iRst_n,
    input  logic [3:0] iResultado,
    input  logic [4:0] iFlags,
    input  logic [3:0] iContador,
    input  logic       iLoad,
    output logic [6:0] oSeg,
    output logic       oDp,
    output logic [3:0] oAnodo,
    output logic       oUpdate
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int PRE_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [PRE_W-1:0] SHOW_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYC - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [PRE_W-1:0] pre_q, pre_d;

    // Held word layout: {result[12:9], counter[8:5], flags[4:0]}
    logic [12:0] held_q, held_d;
    logic [12:0] load_word;
    logic        upd_q, upd_d;

    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;

    logic [3:0]  held_res;
    logic [3:0]  held_cnt;
    logic [4:0]  held_flg;
    logic [3:0]  digit_val;
    logic        dark;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign held_res  = held_q[12:9];
    assign held_cnt  = held_q[8:5];
    assign held_flg  = held_q[4:0];
    assign load_word = {iResultado, iContador, iFlags};

    always_comb begin
        held_d = held_q;
        upd_d  = 1'b0;
        if (iLoad) begin
            held_d = load_word;
            upd_d  = (load_word != held_q);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = pre_q + PRE_W'(1);
        case (state_q)
            ST_SHOW: begin
                if (pre_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    pre_d   = '0;
                end
            end
            ST_BLANK: begin
                if (pre_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    idx_d   = idx_q + 2'd1;
                    pre_d   = '0;
                end
            end
            default: begin
                state_d = ST_BLANK;
                pre_d   = '0;
            end
        endcase
    end

`ifdef DISP_BLINK_EN
    logic [5:0] frm_q, frm_d;
    logic       wrap;

    assign wrap = (state_q == ST_BLANK) && (pre_q == BLANK_LAST) && (idx_q == 2'd3);

    always_comb begin
        frm_d = frm_q;
        if (wrap) begin
            frm_d = frm_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            frm_q <= '0;
        end else begin
            frm_q <= frm_d;
        end
    end

    // Using the next count keeps the whole digit0 slot in one blink phase.
    assign dark = (idx_d == 2'd0) && held_flg[4] && frm_d[5];
`else
    assign dark = 1'b0;
`endif

    always_comb begin
        case (idx_d)
            2'd0:    digit_val = held_res;
            2'd1:    digit_val = held_cnt;
            2'd2:    digit_val = held_flg[3:0];
            default: digit_val = {3'b000, held_flg[4]};
        endcase
    end

    // Outputs follow the next FSM state so they switch on the same edge as the FSM.
    always_comb begin
        seg_d = 7'h7F;
        an_d  = 4'hF;
        dp_d  = 1'b1;
        if ((state_d == ST_SHOW) && !dark) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = hex7(digit_val);
            dp_d  = !((idx_d == 2'd3) && (held_flg != 5'd0));
        end
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_BLANK;
            idx_q   <= 2'd3;
            pre_q   <= '0;
            held_q  <= '0;
            upd_q   <= 1'b0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            held_q  <= held_d;
            upd_q   <= upd_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign oSeg    = seg_q;
    assign oAnodo  = an_q;
    assign oDp     = dp_q;
    assign oUpdate = upd_q;

endmodule
